// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: N-way round-robin arbiter onto one registered
// ready/valid output stage. A winner may keep the port for up to MAX_BURST
// consecutive transfers before priority rotates past it.
// Optional inline assertions: define HANDSHAKE_RR_ARBITER_ASSERT_EN.
module handshake_rr_arbiter #(
    parameter int N         = 3,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    input  logic [N*WIDTH-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_sel
);

    localparam int SEL_W = $clog2(N);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] owner;
    logic [3:0]       burst_cnt;

    logic             load;
    logic             any_valid;
    logic             found;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] winner;
    logic             keep_burst;
    logic [3:0]       next_cnt;

    // Saturating burst counter increment; never wraps past MAX_BURST.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        if (cnt >= BURST_MAX)
            return BURST_MAX;
        return cnt + 4'd1;
    endfunction

    assign load      = !out_valid || out_ready;
    assign any_valid = |in_valid;

    // Winner: a locked owner that is still requesting keeps the port, otherwise
    // scan upward from the lane after the last grant.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        if (state == BURST && in_valid[owner]) begin
            winner = owner;
            found  = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = SEL_W'((int'(last) + k) % N);
                if (!found && in_valid[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // Burst continuation and next count for the grant about to happen.
    always_comb begin
        keep_burst = (state == BURST) && (winner == owner);
        next_cnt   = keep_burst ? sat_inc(burst_cnt) : 4'd1;
    end

    // Grant is one-hot to the winner only when the output slot can load;
    // forced low while reset is held.
    always_comb begin
        in_ready = '0;
        if (ASYNCRESETN && load && any_valid)
            in_ready = N'(1) << winner;
    end

    // Output register, rotation pointer and burst FSM share one slot update.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SEL_W'(N - 1);
            owner     <= '0;
            burst_cnt <= 4'd0;
            state     <= IDLE;
        end else if (load) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data[winner*WIDTH +: WIDTH];
                out_sel   <= winner;
                last      <= winner;
                owner     <= winner;
                burst_cnt <= next_cnt;
                state     <= (next_cnt < BURST_MAX) ? BURST : IDLE;
            end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

`ifdef HANDSHAKE_RR_ARBITER_ASSERT_EN
    localparam logic [7:0] STARVE_MAX = 8'((N - 1) * MAX_BURST);

    a_ready_onehot0: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(in_ready));

    a_stall_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

    a_ready_needs_valid: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (in_ready & ~in_valid) == '0);

    a_burst_bound: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        burst_cnt <= BURST_MAX);

    for (genvar g = 0; g < N; g++) begin : g_starve
        logic [7:0] wait_cnt;

        // Count slot-load cycles a held request goes ungranted.
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN)
                wait_cnt <= '0;
            else if (!in_valid[g] || in_ready[g])
                wait_cnt <= '0;
            else if (load)
                wait_cnt <= wait_cnt + 8'd1;
        end

        a_no_starve: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            wait_cnt <= STARVE_MAX);
    end
`endif

endmodule
